// File: rtl/riscv_pkg.sv
// Shared pipeline constants and types for the integer core.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;
  localparam int unsigned OPW  = 4;

  localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [OPW-1:0] ALU_SLL  = 4'd1;
  localparam logic [OPW-1:0] ALU_SLT  = 4'd2;
  localparam logic [OPW-1:0] ALU_SLTU = 4'd3;
  localparam logic [OPW-1:0] ALU_XOR  = 4'd4;
  localparam logic [OPW-1:0] ALU_SRL  = 4'd5;
  localparam logic [OPW-1:0] ALU_OR   = 4'd6;
  localparam logic [OPW-1:0] ALU_AND  = 4'd7;

  localparam logic [RAW-1:0] REG_X0 = '0;

  // Control bits carried alongside an instruction into the memory stage.
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
  } ctrl_t;

  // A forwarding source applies only when it writes a real register matching rs.
  function automatic logic fwd_hit(input logic           we,
                                   input logic [RAW-1:0] src_rd,
                                   input logic [RAW-1:0] rs);
    return we && (src_rd != REG_X0) && (src_rd == rs);
  endfunction

endpackage

// File: rtl/operand_fwd.sv
// Operand forwarding mux: EX/MEM beats MEM/WB, otherwise the stored value.
module operand_fwd
  import riscv_pkg::*;
(
  input  logic [RAW-1:0]  rs_i,
  input  logic [XLEN-1:0] stored_i,
  input  logic            exm_we_i,
  input  logic [RAW-1:0]  exm_rd_i,
  input  logic [XLEN-1:0] exm_val_i,
  input  logic            mwb_we_i,
  input  logic [RAW-1:0]  mwb_rd_i,
  input  logic [XLEN-1:0] mwb_val_i,
  output logic [XLEN-1:0] val_o
);

  // Priority select of the freshest producer of rs.
  always_comb begin
    val_o = stored_i;
    if (fwd_hit(exm_we_i, exm_rd_i, rs_i)) begin
      val_o = exm_val_i;
    end else if (fwd_hit(mwb_we_i, mwb_rd_i, rs_i)) begin
      val_o = mwb_val_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  input  logic            ID_VALID,
  output logic            ID_READY,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [XLEN-1:0] ID_RD1,
  input  logic [XLEN-1:0] ID_RD2,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic [RAW-1:0]  ID_RS1,
  input  logic [RAW-1:0]  ID_RS2,
  input  logic [RAW-1:0]  ID_RD,
  input  logic [OPW-1:0]  ID_ALU_OP,
  input  logic            ID_ALUSRC,
  input  logic            ID_REGWRITE,
  input  logic            ID_MEMREAD,
  input  logic            ID_MEMWRITE,
  input  logic            EXM_REGWRITE,
  input  logic [RAW-1:0]  EXM_RD,
  input  logic [XLEN-1:0] EXM_VALUE,
  input  logic            MWB_REGWRITE,
  input  logic [RAW-1:0]  MWB_RD,
  input  logic [XLEN-1:0] MWB_VALUE,
  input  logic            EX_READY,
  output logic            EX_VALID,
  output logic [XLEN-1:0] ALU_A,
  output logic [XLEN-1:0] ALU_B,
  output logic [OPW-1:0]  ALU_OP,
  output logic [XLEN-1:0] EX_STORE_DATA,
  output logic [XLEN-1:0] EX_PC,
  output logic [RAW-1:0]  EX_RD,
  output logic            EX_REGWRITE,
  output logic            EX_MEMREAD,
  output logic            EX_MEMWRITE
);

  logic            valid_q,  valid_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] rd1_q,    rd1_d;
  logic [XLEN-1:0] rd2_q,    rd2_d;
  logic [XLEN-1:0] imm_q,    imm_d;
  logic [RAW-1:0]  rs1_q,    rs1_d;
  logic [RAW-1:0]  rs2_q,    rs2_d;
  logic [RAW-1:0]  rd_q,     rd_d;
  logic [OPW-1:0]  op_q,     op_d;
  logic            alusrc_q, alusrc_d;
  ctrl_t           ctrl_q,   ctrl_d;

  logic            advance;
  logic            load_use;
  logic            capture;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] byp_rs1;
  logic [XLEN-1:0] byp_rs2;

  // Forwarding on the held operands.
  operand_fwd u_fwd_rs1 (
    .rs_i      (rs1_q),
    .stored_i  (rd1_q),
    .exm_we_i  (EXM_REGWRITE),
    .exm_rd_i  (EXM_RD),
    .exm_val_i (EXM_VALUE),
    .mwb_we_i  (MWB_REGWRITE),
    .mwb_rd_i  (MWB_RD),
    .mwb_val_i (MWB_VALUE),
    .val_o     (fwd_rs1)
  );

  operand_fwd u_fwd_rs2 (
    .rs_i      (rs2_q),
    .stored_i  (rd2_q),
    .exm_we_i  (EXM_REGWRITE),
    .exm_rd_i  (EXM_RD),
    .exm_val_i (EXM_VALUE),
    .mwb_we_i  (MWB_REGWRITE),
    .mwb_rd_i  (MWB_RD),
    .mwb_val_i (MWB_VALUE),
    .val_o     (fwd_rs2)
  );

  // Capture-path bypass: only MEM/WB, which retires this edge and would
  // otherwise be missed by the register-file read.
  operand_fwd u_byp_rs1 (
    .rs_i      (ID_RS1),
    .stored_i  (ID_RD1),
    .exm_we_i  (1'b0),
    .exm_rd_i  (REG_X0),
    .exm_val_i ('0),
    .mwb_we_i  (MWB_REGWRITE),
    .mwb_rd_i  (MWB_RD),
    .mwb_val_i (MWB_VALUE),
    .val_o     (byp_rs1)
  );

  operand_fwd u_byp_rs2 (
    .rs_i      (ID_RS2),
    .stored_i  (ID_RD2),
    .exm_we_i  (1'b0),
    .exm_rd_i  (REG_X0),
    .exm_val_i ('0),
    .mwb_we_i  (MWB_REGWRITE),
    .mwb_rd_i  (MWB_RD),
    .mwb_val_i (MWB_VALUE),
    .val_o     (byp_rs2)
  );

  // Handshake and hazard detection.
  always_comb begin
    advance  = ~valid_q | EX_READY;
    load_use = valid_q & ctrl_q.memread & (rd_q != REG_X0) & ID_VALID &
               ((ID_RS1 == rd_q) | (ID_RS2 == rd_q));
    ID_READY = RST | FLUSH | (advance & ~load_use);
    capture  = ID_VALID & ID_READY & ~FLUSH & ~RST;
  end

  // Next-state selection: flush, capture, bubble or hold with operand refresh.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    op_d     = op_q;
    alusrc_d = alusrc_q;
    ctrl_d   = ctrl_q;
    if (FLUSH) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (capture) begin
      valid_d  = 1'b1;
      pc_d     = ID_PC;
      rd1_d    = byp_rs1;
      rd2_d    = byp_rs2;
      imm_d    = ID_IMM;
      rs1_d    = ID_RS1;
      rs2_d    = ID_RS2;
      rd_d     = ID_RD;
      op_d     = ID_ALU_OP;
      alusrc_d = ID_ALUSRC;
      ctrl_d   = '{regwrite: ID_REGWRITE, memread: ID_MEMREAD, memwrite: ID_MEMWRITE};
    end else if (advance) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      rd1_d = fwd_rs1;
      rd2_d = fwd_rs2;
    end
  end

  // Stage register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      op_q     <= '0;
      alusrc_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      op_q     <= op_d;
      alusrc_q <= alusrc_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // ALU operands and qualified control towards the memory stage.
  always_comb begin
    EX_VALID      = valid_q;
    ALU_A         = fwd_rs1;
    ALU_B         = alusrc_q ? imm_q : fwd_rs2;
    ALU_OP        = op_q;
    EX_STORE_DATA = fwd_rs2;
    EX_PC         = pc_q;
    EX_RD         = rd_q;
    EX_REGWRITE   = valid_q & ctrl_q.regwrite;
    EX_MEMREAD    = valid_q & ctrl_q.memread;
    EX_MEMWRITE   = valid_q & ctrl_q.memwrite;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus hazard sequences,
// outputs checked against a queue of expected transfers.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, ID_VALID, ID_READY;
  logic [31:0] ID_PC, ID_RD1, ID_RD2, ID_IMM;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD;
  logic [3:0]  ID_ALU_OP;
  logic        ID_ALUSRC, ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE;
  logic        EXM_REGWRITE, MWB_REGWRITE;
  logic [4:0]  EXM_RD, MWB_RD;
  logic [31:0] EXM_VALUE, MWB_VALUE;
  logic        EX_READY, EX_VALID;
  logic [31:0] ALU_A, ALU_B, EX_STORE_DATA, EX_PC;
  logic [3:0]  ALU_OP;
  logic [4:0]  EX_RD;
  logic        EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE;

  id_ex_stage dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .ID_VALID(ID_VALID), .ID_READY(ID_READY),
    .ID_PC(ID_PC), .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_IMM(ID_IMM),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_ALU_OP(ID_ALU_OP),
    .ID_ALUSRC(ID_ALUSRC), .ID_REGWRITE(ID_REGWRITE), .ID_MEMREAD(ID_MEMREAD),
    .ID_MEMWRITE(ID_MEMWRITE),
    .EXM_REGWRITE(EXM_REGWRITE), .EXM_RD(EXM_RD), .EXM_VALUE(EXM_VALUE),
    .MWB_REGWRITE(MWB_REGWRITE), .MWB_RD(MWB_RD), .MWB_VALUE(MWB_VALUE),
    .EX_READY(EX_READY), .EX_VALID(EX_VALID), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_OP(ALU_OP), .EX_STORE_DATA(EX_STORE_DATA), .EX_PC(EX_PC), .EX_RD(EX_RD),
    .EX_REGWRITE(EX_REGWRITE), .EX_MEMREAD(EX_MEMREAD), .EX_MEMWRITE(EX_MEMWRITE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        alusrc, rw, mr, mw;
    logic        exm_we; logic [4:0] exm_rd; logic [31:0] exm_val;
    logic        mwb_we; logic [4:0] mwb_rd; logic [31:0] mwb_val;
    logic [31:0] exp_a, exp_b, exp_sd;
  } vec_t;

  typedef struct {
    logic [31:0] pc, a, b, sd;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[9];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, rd1, rd2, imm,
                       input logic [4:0] rs1, rs2, rd, input logic [3:0] op,
                       input logic alusrc, rw, mr, mw);
    ID_VALID = 1'b1; ID_PC = pc; ID_RD1 = rd1; ID_RD2 = rd2; ID_IMM = imm;
    ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd; ID_ALU_OP = op; ID_ALUSRC = alusrc;
    ID_REGWRITE = rw; ID_MEMREAD = mr; ID_MEMWRITE = mw;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ev,
                         input logic mwe, input logic [4:0] mr, input logic [31:0] mv);
    EXM_REGWRITE = ew; EXM_RD = er; EXM_VALUE = ev;
    MWB_REGWRITE = mwe; MWB_RD = mr; MWB_VALUE = mv;
  endtask

  task automatic push_exp(input logic [31:0] pc, a, b, sd, input logic [3:0] op,
                          input logic [4:0] rd, input logic rw, mr, mw);
    exp_t e;
    e.pc = pc; e.a = a; e.b = b; e.sd = sd; e.op = op; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw;
    sb_q.push_back(e);
  endtask

  // Every transfer to the memory stage is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && EX_VALID && EX_READY) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got pc %h expected no transfer", EX_PC);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_pc", EX_PC, mon_e.pc);
        chk("out_alu_a", ALU_A, mon_e.a);
        chk("out_alu_b", ALU_B, mon_e.b);
        chk("out_store", EX_STORE_DATA, mon_e.sd);
        chk("out_op", {28'd0, ALU_OP}, {28'd0, mon_e.op});
        chk("out_rd", {27'd0, EX_RD}, {27'd0, mon_e.rd});
        chk("out_ctrl", {29'd0, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE},
            {29'd0, mon_e.rw, mon_e.mr, mon_e.mw});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h100, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h5, 32'h7, 32'h7};
    vecs[1] = '{32'h104, 32'h100, 32'h33, 32'hFFFFFFF0, 5'd7, 5'd8, 5'd9, ALU_AND, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h100, 32'hFFFFFFF0, 32'h33};
    vecs[2] = '{32'h108, 32'hAA, 32'h9, 32'h0, 5'd3, 5'd9, 5'd10, ALU_XOR, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 32'h11, 32'h9, 32'h9};
    vecs[3] = '{32'h10C, 32'h77, 32'h66, 32'h0, 5'd0, 5'd0, 5'd11, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 32'h77, 32'h66, 32'h66};
    vecs[4] = '{32'h110, 32'h1, 32'h10, 32'h0, 5'd1, 5'd6, 5'd12, ALU_SLL, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h55, 32'h1, 32'h55, 32'h55};
    vecs[5] = '{32'h114, 32'h5A, 32'h5B, 32'h0, 5'd5, 5'd5, 5'd13, ALU_SLT, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b0, 5'd5, 32'hDEAD, 1'b0, 5'd5, 32'hBEEF, 32'h5A, 32'h5B, 32'h5B};
    vecs[6] = '{32'h118, 32'h1000, 32'h2, 32'h8, 5'd2, 5'd14, 5'd0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1,
                1'b1, 5'd14, 32'hCAFE, 1'b1, 5'd14, 32'hF00D, 32'h1000, 32'h8, 32'hCAFE};
    vecs[7] = '{32'h11C, 32'h2000, 32'h0, 32'h4, 5'd15, 5'd0, 5'd16, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0,
                1'b1, 5'd15, 32'h3000, 1'b0, 5'd0, 32'h0, 32'h3000, 32'h4, 32'h0};
    vecs[8] = '{32'h120, 32'h0, 32'h0, 32'h0, 5'd17, 5'd18, 5'd19, ALU_SLTU, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd18, 32'h18, 1'b1, 5'd17, 32'h17, 32'h17, 32'h18, 32'h18};

    // Reset: offered instruction ignored, ready held high, outputs zero.
    RST = 1'b1; FLUSH = 1'b0; EX_READY = 1'b1;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive(32'hDEAD0000, 32'h9, 32'h9, 32'h9, 5'd1, 5'd2, 5'd3, ALU_AND, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    #1 chk("reset_id_ready", {31'd0, ID_READY}, 32'd1);
    step();
    RST = 1'b0; ID_VALID = 1'b0;
    #1;
    chk("reset_valid", {31'd0, EX_VALID}, 32'd0);
    chk("reset_alu_a", ALU_A, 32'h0);
    chk("reset_alu_b", ALU_B, 32'h0);
    chk("reset_op", {28'd0, ALU_OP}, 32'd0);
    chk("reset_ctrl", {29'd0, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE}, 32'd0);

    // Table: each vector captured, then presented for one cycle with its sources.
    foreach (vecs[i]) begin
      step();
      drive(vecs[i].pc, vecs[i].rd1, vecs[i].rd2, vecs[i].imm, vecs[i].rs1, vecs[i].rs2,
            vecs[i].rd, vecs[i].op, vecs[i].alusrc, vecs[i].rw, vecs[i].mr, vecs[i].mw);
      set_fwd(vecs[i].exm_we, vecs[i].exm_rd, vecs[i].exm_val,
              vecs[i].mwb_we, vecs[i].mwb_rd, vecs[i].mwb_val);
      push_exp(vecs[i].pc, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_sd, vecs[i].op,
               vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].mw);
      #1 chk("vec_id_ready", {31'd0, ID_READY}, 32'd1);
      step();
      ID_VALID = 1'b0;
    end

    // Back-to-back ADDs at full throughput.
    step();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(32'h200 + 32'(4 * k), 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd20, ALU_ADD,
            1'b0, 1'b1, 1'b0, 1'b0);
      push_exp(32'h200 + 32'(4 * k), 32'h5, 32'h7, 32'h7, ALU_ADD, 5'd20, 1'b1, 1'b0, 1'b0);
      #1 chk("b2b_id_ready", {31'd0, ID_READY}, 32'd1);
      if (k > 0) chk("b2b_valid", {31'd0, EX_VALID}, 32'd1);
      step();
    end
    ID_VALID = 1'b0;
    #1 chk("b2b_valid_last", {31'd0, EX_VALID}, 32'd1);

    // Load-use: one bubble, then MEM/WB supplies the loaded value at capture.
    step();
    drive(32'h300, 32'h40, 32'h0, 32'h0, 5'd1, 5'd0, 5'd4, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0);
    push_exp(32'h300, 32'h40, 32'h0, 32'h0, ALU_ADD, 5'd4, 1'b1, 1'b1, 1'b0);
    step();
    drive(32'h304, 32'hBAD, 32'h3, 32'h0, 5'd4, 5'd21, 5'd22, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_id_ready", {31'd0, ID_READY}, 32'd0);
    step();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h4444);
    push_exp(32'h304, 32'h4444, 32'h3, 32'h3, ALU_ADD, 5'd22, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_bubble_valid", {31'd0, EX_VALID}, 32'd0);
    chk("lu_release_ready", {31'd0, ID_READY}, 32'd1);
    step();
    ID_VALID = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 chk("lu_after_valid", {31'd0, EX_VALID}, 32'd1);

    // Stall refresh: MEM/WB result seen only in the first held cycle survives.
    step();
    drive(32'h400, 32'h1, 32'h10, 32'h0, 5'd1, 5'd6, 5'd23, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(32'h400, 32'h1, 32'h55, 32'h55, ALU_ADD, 5'd23, 1'b1, 1'b0, 1'b0);
    step();
    ID_VALID = 1'b0; EX_READY = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h55);
    #1 chk("stall_id_ready", {31'd0, ID_READY}, 32'd0);
    step();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 chk("stall_hold_valid", {31'd0, EX_VALID}, 32'd1);
    step();
    step();
    EX_READY = 1'b1;

    // FLUSH while stalled kills the held instruction and drops the incoming one.
    step();
    drive(32'h500, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd24, ALU_SRL, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    EX_READY = 1'b0; FLUSH = 1'b1;
    drive(32'h504, 32'h3, 32'h4, 32'h0, 5'd3, 5'd5, 5'd25, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    #1 chk("flush_id_ready", {31'd0, ID_READY}, 32'd1);
    step();
    FLUSH = 1'b0; ID_VALID = 1'b0; EX_READY = 1'b1;
    #1;
    chk("flush_valid", {31'd0, EX_VALID}, 32'd0);
    chk("flush_ctrl", {29'd0, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE}, 32'd0);
    step();
    #1 chk("flush_no_capture", {31'd0, EX_VALID}, 32'd0);

    // FLUSH overrides a load-use stall.
    drive(32'h600, 32'h60, 32'h0, 32'h0, 5'd1, 5'd0, 5'd4, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0);
    push_exp(32'h600, 32'h60, 32'h0, 32'h0, ALU_ADD, 5'd4, 1'b1, 1'b1, 1'b0);
    step();
    FLUSH = 1'b1;
    drive(32'h604, 32'h1, 32'h1, 32'h0, 5'd4, 5'd0, 5'd5, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("flush_lu_ready", {31'd0, ID_READY}, 32'd1);
    step();
    FLUSH = 1'b0; ID_VALID = 1'b0;
    #1 chk("flush_lu_valid", {31'd0, EX_VALID}, 32'd0);

    // Reset during a hold.
    step();
    drive(32'h700, 32'h70, 32'h71, 32'h0, 5'd1, 5'd2, 5'd26, ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    ID_VALID = 1'b0; EX_READY = 1'b0;
    #1 chk("rst_hold_valid", {31'd0, EX_VALID}, 32'd1);
    step();
    RST = 1'b1;
    #1 chk("rst_id_ready", {31'd0, ID_READY}, 32'd1);
    step();
    RST = 1'b0;
    #1;
    chk("rst_valid", {31'd0, EX_VALID}, 32'd0);
    chk("rst_alu_a", ALU_A, 32'h0);
    chk("rst_alu_b", ALU_B, 32'h0);
    chk("rst_op", {28'd0, ALU_OP}, 32'd0);
    chk("rst_store", EX_STORE_DATA, 32'h0);
    EX_READY = 1'b1;

    // Capture bypass: MEM/WB value present only at capture is retained.
    step();
    drive(32'h800, 32'h1, 32'h0, 32'h0, 5'd8, 5'd0, 5'd27, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88);
    push_exp(32'h800, 32'h88, 32'h0, 32'h0, ALU_ADD, 5'd27, 1'b1, 1'b0, 1'b0);
    step();
    ID_VALID = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    step();

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the ALU. It registers one decoded instruction, resolves operand hazards by forwarding from EX/MEM and MEM/WB, and inserts a one-cycle bubble on load-use. It presents A/B/OP to the ALU and passes control fields to the memory stage. The valid/ready handshake runs on both sides.

## Interface
- XLEN, 32, datapath width
- OPW, 4, ALU op width (matches ALU OP port)
- RAW, 5, register address width
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- FLUSH  in  1  kill held instruction and incoming instruction (branch/jump redirect)
- ID_VALID  in  1  decode offers instruction
- ID_READY  out  1  stage accepts instruction this cycle
- ID_PC  in  XLEN  instruction PC
- ID_RD1, ID_RD2  in  XLEN  register-file read data
- ID_IMM  in  XLEN  sign-extended immediate
- ID_RS1, ID_RS2, ID_RD  in  RAW  register indices
- ID_ALU_OP  in  OPW  ALU operation
- ID_ALUSRC  in  1  1: B = immediate, 0: B = rs2 value
- ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE  in  1  control bits
- EXM_REGWRITE  in  1; EXM_RD  in  RAW; EXM_VALUE  in  XLEN  EX/MEM forwarding source
- MWB_REGWRITE  in  1; MWB_RD  in  RAW; MWB_VALUE  in  XLEN  MEM/WB forwarding source
- EX_READY  in  1  downstream accepts
- EX_VALID  out  1  held instruction valid
- ALU_A, ALU_B  out  XLEN  ALU operands
- ALU_OP  out  OPW  ALU operation
- EX_STORE_DATA  out  XLEN  forwarded rs2 value
- EX_PC  out  XLEN; EX_RD  out  RAW; EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE  out  1

## Operation
- advance = ~EX_VALID | EX_READY.
- load_use = EX_VALID & EX_MEMREAD & (EX_RD != 0) & ID_VALID & (ID_RS1 == EX_RD | ID_RS2 == EX_RD). The rs2 compare is deliberate and unconditional; it accepts spurious stalls.
- ID_READY = FLUSH | (advance & ~load_use).
- Capture (ID_VALID & ID_READY & ~FLUSH): latch all ID fields. RD1/RD2 are latched through a MEM/WB bypass: if MWB_REGWRITE, MWB_RD != 0 and MWB_RD == rs, latch MWB_VALUE.
- Bubble: advance & ~capture. EX_VALID <= 0, and all control bits are cleared.
- Hold (~advance): all fields are kept. Stored RD1/RD2 are refreshed each held cycle with their forwarded values, so a source that retires during the stall is not lost.
- FLUSH: EX_VALID <= 0 next edge, regardless of EX_READY. The ID instruction is consumed and discarded.
- Forwarding, combinational on the held rs1/rs2:
  - EX/MEM match wins over MEM/WB match; otherwise the stored value is used.
  - x0 is never forwarded.
  - A source forwards only with its REGWRITE set.
- ALU_A = fwd(rs1). ALU_B = ALUSRC ? IMM : fwd(rs2). EX_STORE_DATA = fwd(rs2).
- Control outputs are qualified: EX_REGWRITE/MEMREAD/MEMWRITE are 0 whenever EX_VALID = 0.

## Timing
- Latency 1 cycle, ID capture to EX outputs. Throughput 1 per cycle when EX_READY = 1.
- Reset values: EX_VALID 0, every registered field 0. Consequently ALU_OP 0, ALU_A 0, ALU_B 0, EX_STORE_DATA 0, and all control outputs 0.
- ID_READY during reset is 1; nothing is captured.
- Load-use costs exactly one bubble cycle. The next cycle the load has advanced and MEM/WB forwarding supplies the value.
- Simultaneous FLUSH and load_use: FLUSH wins, ID_READY = 1, nothing captured.
- Simultaneous FLUSH and ~EX_READY: the held instruction is still killed.
- RST mid-stall or mid-flush: the state is discarded and reset values appear at the next edge.
- Operand outputs may change during a hold as forwarding sources move. Downstream samples only on the EX_VALID & EX_READY edge.

## Structure
- Shared package `riscv_pkg`:
  - XLEN, RAW, OPW
  - ALU op constants: ALU_ADD=0, ALU_SLL=1, ALU_SLT=2, ALU_SLTU=3, ALU_XOR=4, ALU_SRL=5, ALU_OR=6, ALU_AND=7
  - REG_X0
- Sub-module `operand_fwd`: rs, stored value, two forwarding sources in, selected value out. It is instanced for rs1, for rs2, and at the capture-path bypass.

## Test plan
- Back-to-back ADD: ID x1=5, x2=7, OP=0, EX_READY=1 for 3 cycles -> EX_VALID high one cycle later each time, ALU_A=5, ALU_B=7, no bubble.
- EX/MEM forward priority: held rs1=3, EXM_RD=3 value 0x11, MWB_RD=3 value 0x22 -> ALU_A=0x11. Same with rs1=0 -> ALU_A = stored value.
- Load-use: held LW rd=4, ID rs1=4 -> ID_READY=0 one cycle, EX_VALID=0 next, then capture. ALU_A = MWB_VALUE when MWB_RD=4.
- Stall refresh: EX_READY=0 for 3 cycles, with MWB writing rs2=6 value 0x55 in cycle 1 only -> after release, ALU_B=0x55 (ALUSRC=0).
- FLUSH with EX_READY=0 and ID_VALID=1 -> next cycle EX_VALID=0, all control outputs 0, ID instruction not captured.
- RST asserted mid-hold -> next edge EX_VALID=0, ALU_A=ALU_B=0, ALU_OP=0.
